// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage with a req/ack data-memory bus.
// Optional MEM_TIMEOUT_EN abandons a wait after TIMEOUT_CYCLES cycles without ack.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_write_reg,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              mem_err
);
  typedef enum logic {IDLE, MEM_WAIT} state_t;
  state_t state_q;
  logic squash_q, ld_q, m2r_q, rw_q;
  logic [REG_AW-1:0] wreg_q;
  logic [DATA_W-1:0] alu_q;
  logic accept, mem_op, misaligned, squash, timeout, done;
  assign in_ready   = state_q == IDLE;
  assign accept     = in_valid & in_ready & ~flush;
  assign mem_op     = ex_mem_read | ex_mem_write;
  assign misaligned = |ex_alu_result[1:0];
  assign squash     = squash_q | flush;
  assign done       = state_q == MEM_WAIT && (dmem_ack || timeout);
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  assign timeout = state_q == MEM_WAIT && !dmem_ack && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (state_q == MEM_WAIT) ? cnt_q + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      squash_q      <= 1'b0;
      ld_q          <= 1'b0;
      m2r_q         <= 1'b0;
      rw_q          <= 1'b0;
      wreg_q        <= '0;
      alu_q         <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
      mem_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        if (mem_op && !misaligned) begin
          state_q    <= MEM_WAIT;
          squash_q   <= 1'b0;
          dmem_req   <= 1'b1;
          dmem_we    <= ex_mem_write & ~ex_mem_read;
          dmem_addr  <= ADDR_W'(ex_alu_result);
          dmem_wdata <= ex_store_data;
          ld_q       <= ex_mem_read;
          m2r_q      <= ex_mem_to_reg;
          rw_q       <= ex_reg_write & (|ex_write_reg);
          wreg_q     <= ex_write_reg;
          alu_q      <= ex_alu_result;
          if (ex_mem_read && ex_mem_write) mem_err <= 1'b1;
        end else begin
          wb_valid      <= 1'b1;
          wb_reg_write  <= ~mem_op & ex_reg_write & (|ex_write_reg);
          wb_write_reg  <= ex_write_reg;
          wb_write_data <= ex_alu_result;
          if (mem_op) mem_err <= 1'b1;
        end
      end
      if (state_q == MEM_WAIT) begin
        if (flush) squash_q <= 1'b1;
        if (done) begin
          state_q  <= IDLE;
          dmem_req <= 1'b0;
          squash_q <= 1'b0;
          wb_valid <= ~squash;
          if (timeout) mem_err <= 1'b1;
          if (!squash) begin
            wb_reg_write  <= ld_q & rw_q & ~timeout;
            wb_write_reg  <= wreg_q;
            wb_write_data <= (ld_q && m2r_q && !timeout) ? dmem_rdata : alu_q;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table plus hand sequences for mem_wb_stage.
module tb_mem_wb_stage;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, ex_reg_write = 0, ex_mem_to_reg = 0, ex_mem_read = 0, ex_mem_write = 0;
  logic [31:0] ex_alu_result = 0, ex_store_data = 0, dmem_addr, dmem_wdata, dmem_rdata = 0, wb_write_data;
  logic [4:0] ex_write_reg = 0, wb_write_reg;
  logic flush = 0, dmem_req, dmem_we, dmem_ack = 0, wb_valid, wb_reg_write, mem_err;
  int total = 0, passed = 0;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .mem_err(mem_err));

  always #5 clk = ~clk;

  typedef struct {
    logic v, fl, rw, m2r, rd, wr;
    logic [31:0] alu;
    logic [4:0] wreg;
    logic e_v, e_rw;
    logic [31:0] e_d;
    logic e_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, fl, rw, m2r, rd, wr, input logic [31:0] alu, sd, input logic [4:0] wreg);
    in_valid = v; flush = fl; ex_reg_write = rw; ex_mem_to_reg = m2r;
    ex_mem_read = rd; ex_mem_write = wr; ex_alu_result = alu; ex_store_data = sd; ex_write_reg = wreg;
  endtask

  initial begin
    vecs[0] = '{1, 0, 1, 0, 0, 0, 32'h1234, 5'd8, 1, 1, 32'h1234, 0};
    vecs[1] = '{1, 0, 1, 0, 0, 0, 32'hABCD, 5'd3, 1, 1, 32'hABCD, 0};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 32'h77,   5'd0, 1, 0, 32'h77,   0};
    vecs[3] = '{1, 0, 0, 0, 0, 0, 32'h9,    5'd5, 1, 0, 32'h9,    0};
    vecs[4] = '{0, 0, 1, 0, 0, 0, 32'h66,   5'd6, 0, 0, 32'h9,    0};
    vecs[5] = '{1, 1, 1, 0, 0, 0, 32'h55,   5'd6, 0, 0, 32'h9,    0};
    vecs[6] = '{1, 0, 1, 1, 1, 0, 32'h102,  5'd4, 1, 0, 32'h102,  1};
    vecs[7] = '{1, 0, 1, 0, 0, 1, 32'h203,  5'd4, 1, 0, 32'h203,  1};
    #2;
    chk("rst_in_ready", in_ready, 1); chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_err", mem_err, 0); chk("rst_wdata", wb_write_data, 0);
    step; rst_n = 1; step;
    // load, ack three cycles after request
    drive(1, 0, 1, 1, 1, 0, 32'h100, 32'h0, 5'd9); step; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ld_req", dmem_req, 1); chk("ld_we", dmem_we, 0); chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_ready", in_ready, 0); chk("ld_wbv0", wb_valid, 0);
    for (int i = 0; i < 2; i++) begin
      step; chk("ld_hold_req", dmem_req, 1); chk("ld_hold_addr", dmem_addr, 32'h100); chk("ld_hold_ready", in_ready, 0);
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; step; dmem_ack = 0;
    chk("ld_wbv", wb_valid, 1); chk("ld_data", wb_write_data, 32'hDEADBEEF); chk("ld_rw", wb_reg_write, 1);
    chk("ld_wreg", wb_write_reg, 9); chk("ld_req_off", dmem_req, 0); chk("ld_ready1", in_ready, 1);
    step; chk("ld_pulse", wb_valid, 0);
    dmem_ack = 1; step; dmem_ack = 0;
    chk("idle_ack_wbv", wb_valid, 0); chk("idle_ack_req", dmem_req, 0);
    // store acked in first request cycle
    drive(1, 0, 1, 0, 0, 1, 32'h200, 32'h55, 5'd2); step; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("st_req", dmem_req, 1); chk("st_we", dmem_we, 1); chk("st_wdata", dmem_wdata, 32'h55); chk("st_addr", dmem_addr, 32'h200);
    dmem_ack = 1; step; dmem_ack = 0;
    chk("st_wbv", wb_valid, 1); chk("st_rw", wb_reg_write, 0); chk("st_ready", in_ready, 1); chk("st_req_off", dmem_req, 0);
    // flush while waiting on a load
    drive(1, 0, 1, 1, 1, 0, 32'h300, 0, 5'd7); step; drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step; flush = 0;
    chk("fl_req", dmem_req, 1); chk("fl_ready", in_ready, 0);
    step; dmem_ack = 1; dmem_rdata = 32'h1; step; dmem_ack = 0;
    chk("fl_wbv", wb_valid, 0); chk("fl_req_off", dmem_req, 0); chk("fl_ready1", in_ready, 1);
    chk("fl_data_hold", wb_write_data, 32'h200);
    drive(1, 0, 1, 0, 0, 0, 32'h42, 0, 5'd7); step;
    chk("fl_next_wbv", wb_valid, 1); chk("fl_next_data", wb_write_data, 32'h42);
    // single-cycle table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].v, vecs[i].fl, vecs[i].rw, vecs[i].m2r, vecs[i].rd, vecs[i].wr, vecs[i].alu, 32'h0, vecs[i].wreg);
      step;
      chk($sformatf("vec%0d_wbv", i), wb_valid, vecs[i].e_v);
      chk($sformatf("vec%0d_rw", i), wb_reg_write, vecs[i].e_rw);
      chk($sformatf("vec%0d_data", i), wb_write_data, vecs[i].e_d);
      chk($sformatf("vec%0d_err", i), mem_err, vecs[i].e_err);
      chk($sformatf("vec%0d_req", i), dmem_req, 0);
      chk($sformatf("vec%0d_ready", i), in_ready, 1);
    end
    // read and write both set behaves as a load
    drive(1, 0, 1, 1, 1, 1, 32'h500, 32'hAA, 5'd10); step; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rw_req", dmem_req, 1); chk("rw_we", dmem_we, 0);
    dmem_ack = 1; dmem_rdata = 32'h99; step; dmem_ack = 0;
    chk("rw_wbv", wb_valid, 1); chk("rw_data", wb_write_data, 32'h99); chk("rw_rw", wb_reg_write, 1);
    // async reset mid-access
    drive(1, 0, 1, 1, 1, 0, 32'h600, 0, 5'd11); step; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ar_req", dmem_req, 1);
    #3 rst_n = 0; #1;
    chk("ar_req_drop", dmem_req, 0); chk("ar_ready", in_ready, 1); chk("ar_err", mem_err, 0);
    #1 rst_n = 1;
    dmem_ack = 1; step; dmem_ack = 0;
    chk("ar_ack_ignored", wb_valid, 0);
`ifdef MEM_TIMEOUT_EN
    drive(1, 0, 1, 1, 1, 0, 32'h400, 0, 5'd12); step; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("to_req", dmem_req, 1);
    for (int i = 0; i < 3; i++) begin
      step; chk("to_wait_req", dmem_req, 1);
    end
    step;
    chk("to_req_off", dmem_req, 0); chk("to_err", mem_err, 1); chk("to_ready", in_ready, 1);
    chk("to_wbv", wb_valid, 1); chk("to_rw", wb_reg_write, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
